// File: rtl/satellite_fuzzer_gen2_if.sv
// Bundles the Central Fuzzer register bus and the stimulus/response channel to the IP.
// The master modport is the fuzzer's view; the slave modport is the environment's view.
interface satellite_fuzzer_gen2_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic                  hwrite;
  logic [3:0]            haddr;
  logic [31:0]           hwdata;
  logic [31:0]           hrdata;
  logic                  stim_valid;
  logic                  stim_ready;
  logic [DATA_WIDTH-1:0] stim_a;
  logic [DATA_WIDTH-1:0] stim_b;
  logic [3:0]            stim_op;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    input  hsel, hwrite, haddr, hwdata, stim_ready, resp_valid, resp_data,
    output hrdata, stim_valid, stim_a, stim_b, stim_op
  );

  modport slave (
    output hsel, hwrite, haddr, hwdata, stim_ready, resp_valid, resp_data,
    input  hrdata, stim_valid, stim_a, stim_b, stim_op
  );
endinterface

// File: rtl/satellite_fuzzer_gen2.sv
// Autonomous stimulus engine: issues LFSR or seed-mutated ALU patterns, checks responses
// against a golden model and reports hang/overflow/mismatch through addressed registers.
module satellite_fuzzer_gen2 #(
  parameter int          DATA_WIDTH      = 32,
  parameter int          NUM_PATTERNS    = 16,
  parameter int          MAX_WAIT_CYCLES = 100,
  parameter logic [31:0] LFSR_SEED       = 32'hACE12345
) (
  input  logic                   clk,
  input  logic                   rst_n,
  satellite_fuzzer_gen2_if.master bus,
  output logic                   busy,
  output logic                   done
);
  localparam int          DW   = DATA_WIDTH;
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, HANG, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]    mode;
  logic [DW-1:0] seed;
  logic [31:0]   lfsr, lfsr_nxt;
  logic [15:0]   pattern_cnt, error_cnt, wait_cnt;
  logic          hang_f, ovf_f, mis_f;
  logic [DW-1:0] a_q, b_q, resp_q;
  logic [3:0]    op_q;

  logic          running, ctrl_wr, seed_wr, start_go, abort, accept, timeout, last_pat, load;
  logic          mism, ovf;
  logic [1:0]    eff_mode;
  logic [15:0]   nidx, sh, code;
  logic [DW:0]   sum;
  logic [DW-1:0] golden, a_nxt, b_nxt, rev_a;
  logic [3:0]    op_nxt;
  logic [31:0]   seed_ext;

  assign running  = (state == ISSUE) || (state == WAIT) || (state == CHECK) || (state == HANG);
  assign ctrl_wr  = bus.hsel && bus.hwrite && (bus.haddr == 4'h0);
  assign seed_wr  = bus.hsel && bus.hwrite && (bus.haddr == 4'h4);
  assign start_go = ctrl_wr && !running && bus.hwdata[2] &&
                    ((bus.hwdata[1:0] == 2'd1) || (bus.hwdata[1:0] == 2'd2));
  assign abort    = ctrl_wr && running && (bus.hwdata[1:0] == 2'd0);
  assign accept   = (state == ISSUE) && bus.stim_ready;
  // wait_cnt reads k in the k-th ISSUE/WAIT cycle, so the last allowed cycle is MAX-2
  assign timeout  = (wait_cnt + 16'd1) == 16'(MAX_WAIT_CYCLES - 1);
  assign last_pat = (pattern_cnt + 16'd1) == 16'(NUM_PATTERNS);
  assign eff_mode = start_go ? bus.hwdata[1:0] : mode;
  assign load     = (state_nxt == ISSUE) && (state != ISSUE);
  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_go) state_nxt = ISSUE;
      ISSUE: begin
        if (abort)        state_nxt = IDLE;
        else if (timeout) state_nxt = HANG;
        else if (accept)  state_nxt = WAIT;
      end
      WAIT: begin
        if (abort)               state_nxt = IDLE;
        else if (bus.resp_valid) state_nxt = CHECK;
        else if (timeout)        state_nxt = HANG;
      end
      CHECK:   state_nxt = abort ? IDLE : (last_pat ? DONE : ISSUE);
      HANG:    state_nxt = abort ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are latched on ISSUE entry, so they stay valid for the golden check after the LFSR steps
  always_comb begin
    rev_a = '0;
    for (int i = 0; i < DW; i++) rev_a[i] = lfsr[DW-1-i];
    nidx = (state == CHECK) ? (pattern_cnt + 16'd1) : 16'd0;
    sh   = nidx % 16'(DW);
    if (eff_mode == 2'd2) begin
      a_nxt  = seed ^ (ONE << sh);
      b_nxt  = ~seed;
      op_nxt = 4'(nidx % 16'd5);
    end else begin
      a_nxt  = lfsr[DW-1:0];
      b_nxt  = rev_a;
      op_nxt = {1'b0, lfsr[DW-1 -: 3]};
    end
  end

  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    case (op_q)
      4'd0:    golden = sum[DW-1:0];
      4'd1:    golden = a_q - b_q;
      4'd2:    golden = a_q & b_q;
      4'd3:    golden = a_q | b_q;
      4'd4:    golden = a_q ^ b_q;
      default: golden = '0;
    endcase
    mism = (resp_q != golden);
    ovf  = (op_q == 4'd0) && sum[DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= '0; seed <= '0; lfsr <= LFSR_SEED;
      pattern_cnt <= '0; error_cnt <= '0; wait_cnt <= '0;
      hang_f <= 1'b0; ovf_f <= 1'b0; mis_f <= 1'b0;
      a_q <= '0; b_q <= '0; op_q <= '0; resp_q <= '0;
    end else begin
      if (ctrl_wr && (!running || bus.hwdata[1:0] == 2'd0)) mode <= bus.hwdata[1:0];
      if (seed_wr && !running) seed <= bus.hwdata[DW-1:0];
      if (accept) lfsr <= lfsr_nxt;
      if (load) begin
        a_q <= a_nxt; b_q <= b_nxt; op_q <= op_nxt; wait_cnt <= '0;
      end else if (state == ISSUE || state == WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (state == WAIT && bus.resp_valid) resp_q <= bus.resp_data;
      if (start_go) begin
        pattern_cnt <= '0; error_cnt <= '0;
        hang_f <= 1'b0; ovf_f <= 1'b0; mis_f <= 1'b0;
      end else if (state == CHECK) begin
        pattern_cnt <= pattern_cnt + 16'd1;
        if (ovf)  ovf_f <= 1'b1;
        if (mism) mis_f <= 1'b1;
        if ((ovf || mism) && error_cnt != 16'hFFFF) error_cnt <= error_cnt + 16'd1;
      end else if (state == HANG) begin
        hang_f <= 1'b1;
        if (error_cnt != 16'hFFFF) error_cnt <= error_cnt + 16'd1;
      end
    end
  end

  assign bus.stim_valid = (state == ISSUE);
  assign bus.stim_a     = a_q;
  assign bus.stim_b     = b_q;
  assign bus.stim_op    = op_q;
  assign busy           = running;
  assign done           = (state == DONE);

  always_comb begin
    seed_ext         = '0;
    seed_ext[DW-1:0] = seed;
    code = hang_f ? 16'hBEEF : (ovf_f ? 16'hC0DE : (mis_f ? 16'hFFFF : 16'h0000));
    case (bus.haddr)
      4'h0:    bus.hrdata = {30'b0, mode};
      4'h4:    bus.hrdata = seed_ext;
      4'h8:    bus.hrdata = {code, 11'b0, done, busy, 1'b0, mode};
      4'hC:    bus.hrdata = {error_cnt, pattern_cnt};
      default: bus.hrdata = '0;
    endcase
  end
endmodule

// File: tb/tb_satellite_fuzzer_gen2.sv
// Directed bench for satellite_fuzzer_gen2: reset, stall, hang, random with corruption,
// mutated campaign and abort, with an ideal ALU responder on the stimulus channel.
module tb_satellite_fuzzer_gen2;
  logic clk;
  logic rst_n;
  logic busy, done;
  int   tests = 0;
  int   fails = 0;
  logic withhold;
  int   corrupt_idx;

  satellite_fuzzer_gen2_if #(.DATA_WIDTH(32)) bus();

  satellite_fuzzer_gen2 #(
    .DATA_WIDTH(32), .NUM_PATTERNS(16), .MAX_WAIT_CYCLES(100), .LFSR_SEED(32'hACE12345)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  // Errors and overflow over n random patterns starting from LFSR state s0; pattern bad is corrupted
  task automatic model_rand(input logic [31:0] s0, input int n, input int bad,
                            output int e, output logic ov, output logic [31:0] s_end);
    logic [31:0] s, ta;
    logic [32:0] sm;
    logic        o;
    s = s0; e = 0; ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      ta = s;
      sm = {1'b0, ta} + {1'b0, rev32(ta)};
      o  = (ta[31:29] == 3'b000) && sm[32];
      if (o) ov = 1'b1;
      if (o || i == bad) e++;
      s = lfsr_step(s);
    end
    s_end = s;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.hsel = 1'b1; bus.hwrite = 1'b1; bus.haddr = a; bus.hwdata = d;
    @(posedge clk); #1;
    bus.hsel = 1'b0; bus.hwrite = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.haddr = a;
    #1 d = bus.hrdata;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Ideal ALU IP: answers one cycle after acceptance unless told to withhold or corrupt
  initial begin
    logic        acc;
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    int          idx;
    bus.resp_valid = 1'b0; bus.resp_data = '0; idx = 0;
    forever begin
      @(negedge clk);
      acc = bus.stim_valid && bus.stim_ready;
      ra = bus.stim_a; rb = bus.stim_b; rop = bus.stim_op;
      if (!busy) idx = 0;
      @(posedge clk); #1;
      bus.resp_valid = 1'b0;
      if (acc) begin
        if (!(withhold && idx == 0)) begin
          bus.resp_valid = 1'b1;
          bus.resp_data  = alu(ra, rb, rop) ^ ((idx == corrupt_idx) ? 32'd1 : 32'd0);
        end
        idx++;
      end
    end
  end

  initial begin
    logic [31:0] d, exp_a, m_lfsr, s_end;
    int          cyc, nb, rises, e;
    logic        ov, prev;
    rst_n = 1'b0; bus.hsel = 1'b0; bus.hwrite = 1'b0; bus.haddr = '0; bus.hwdata = '0;
    bus.stim_ready = 1'b0; withhold = 1'b0; corrupt_idx = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(bus.stim_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rd(4'h8, d); check("rst_status", d, 32'h0);
    rd(4'hC, d); check("rst_count", d, 32'h0);
    rd(4'h4, d); check("rst_seed", d, 32'h0);

    // Stall in ISSUE: operands must hold, then async reset drops stim_valid at once
    @(negedge clk); wr(4'h0, 32'h5);
    exp_a = 32'hACE12345;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.stim_valid), 32'd1);
      check("stall_a", bus.stim_a, exp_a);
      check("stall_b", bus.stim_b, rev32(exp_a));
      check("stall_op", 32'(bus.stim_op), 32'd5);
    end
    #2 rst_n = 1'b0;
    #1 check("rst_issue_valid", 32'(bus.stim_valid), 32'd0);
    check("rst_issue_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-WAIT
    @(posedge clk); #1; bus.stim_ready = 1'b1; withhold = 1'b1;
    @(negedge clk); wr(4'h0, 32'h5);
    repeat (3) @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_wait_valid", 32'(bus.stim_valid), 32'd0);
    rd(4'h8, d); check("rst_wait_status", d, 32'h0);
    rd(4'hC, d); check("rst_wait_count", d, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Hang on pattern 0: 99 ISSUE/WAIT cycles plus one HANG cycle
    @(negedge clk); wr(4'h0, 32'h5);
    cyc = 0; nb = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      if (cyc == 0) check("hang_lfsr_restart", bus.stim_a, 32'hACE12345);
      cyc++;
      if (busy) nb++;
    end
    check("hang_done", 32'(done), 32'd1);
    check("hang_busy_cycles", 32'(nb), 32'd100);
    rd(4'h8, d); check("hang_status", d, 32'hBEEF0011);
    rd(4'hC, d); check("hang_count", d, 32'h00010000);
    m_lfsr = lfsr_step(32'hACE12345);
    withhold = 1'b0;

    // Random campaign, ready stalled 10 cycles on pattern 0, pattern 3 corrupted
    @(posedge clk); #1; bus.stim_ready = 1'b0; corrupt_idx = 3;
    @(negedge clk); wr(4'h0, 32'h5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rstall_valid", 32'(bus.stim_valid), 32'd1);
      check("rstall_a", bus.stim_a, m_lfsr);
      check("rstall_b", bus.stim_b, rev32(m_lfsr));
    end
    @(posedge clk); #1; bus.stim_ready = 1'b1;
    wait_done("rand", 2000);
    model_rand(m_lfsr, 16, 3, e, ov, s_end);
    rd(4'hC, d); check("rand_count", d, {16'(e), 16'd16});
    rd(4'h8, d); check("rand_status", d, {(ov ? 16'hC0DE : 16'hFFFF), 16'h0011});
    m_lfsr = s_end;
    corrupt_idx = -1;

    // Mutated campaign from SEED=0xF: adds on patterns 5, 10, 15 carry out
    @(negedge clk); wr(4'h4, 32'h0000000F);
    rd(4'h4, d); check("seed_read", d, 32'h0000000F);
    @(negedge clk); wr(4'h0, 32'h6);
    @(negedge clk);
    check("mut_p0_valid", 32'(bus.stim_valid), 32'd1);
    check("mut_p0_a", bus.stim_a, 32'h0000000E);
    check("mut_p0_b", bus.stim_b, 32'hFFFFFFF0);
    check("mut_p0_op", 32'(bus.stim_op), 32'd0);
    wait_done("mut", 2000);
    rd(4'h8, d); check("mut_status", d, 32'hC0DE0012);
    rd(4'hC, d); check("mut_count", d, 32'h00030010);

    // Abort while pattern 5 is issuing
    @(negedge clk); wr(4'h0, 32'h5);
    rises = 0; prev = 1'b0; cyc = 0;
    while (rises < 6 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (bus.stim_valid && !prev) rises++;
      prev = bus.stim_valid;
    end
    check("abort_reached_p5", 32'(rises), 32'd6);
    wr(4'h0, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_valid", 32'(bus.stim_valid), 32'd0);
    model_rand(m_lfsr, 5, -1, e, ov, s_end);
    rd(4'hC, d); check("abort_count", d, {16'(e), 16'd5});
    rd(4'h8, d); check("abort_status_lo", {16'h0, d[15:0]}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
